// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: per-channel synchronizer chain, debounce
// filter and registered rise/fall edge pulses in the clk domain.
module sync_debounce #(
    parameter int             N         = 8,
    parameter int             STAGES    = 2,
    parameter int             DB_CYCLES = 4,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         changed
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_debounce: STAGES must be >= 2");
        end
        if (DB_CYCLES < 1) begin : g_bad_db
            $error("sync_debounce: DB_CYCLES must be >= 1");
        end
    endgenerate

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync [STAGES];
    logic [N-1:0]  s;
    logic [CW-1:0] cnt     [N];
    logic [CW-1:0] cnt_nxt [N];
    logic [N-1:0]  q_nxt;

    // Plain shift chain, no logic between stages; ignores en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync[i] <= RESET_VAL;
            end
        end else begin
            sync[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
        end
    end

    assign s = sync[STAGES-1];

    always_comb begin
        q_nxt = q;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_nxt[i] = cnt[i];
            if (s[i] == q[i]) begin
                cnt_nxt[i] = '0;
            end else if (en) begin
                if (cnt[i] == CNT_LAST) begin
                    q_nxt[i]   = s[i];
                    cnt_nxt[i] = '0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pulses derive from q_nxt vs q so they land on the same edge as q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= RESET_VAL;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            q       <= q_nxt;
            rise    <= q_nxt & ~q;
            fall    <= ~q_nxt & q;
            changed <= |(q_nxt ^ q);
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Multi-channel input conditioner for asynchronous, slow, or bouncy signals such as buttons, switches and external status lines.
- Each of N channels passes through a parametrised-depth synchronizer chain, then a per-channel debounce filter, then an edge detector.
- Produces a clean level output plus one-cycle rise/fall pulses in the clk domain.
- Sits at the chip/board boundary, in front of any FSM that consumes external inputs.

Parameters:
N, 8, number of independent input channels
STAGES, 2, synchronizer flop depth per channel; must be >= 2
DB_CYCLES, 4, consecutive enabled samples a new level must hold before q accepts it; must be >= 1 (1 = no filtering)
RESET_VAL, '0, N-bit value loaded into the sync chain and q on reset

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
en  input  1  debounce sample enable (tick); the sync chain ignores it
d  input  N  asynchronous raw inputs
q  output  N  synchronized, debounced levels
rise  output  N  one-cycle pulse per channel on a 0->1 change of q
fall  output  N  one-cycle pulse per channel on a 1->0 change of q
changed  output  1  OR of all rise and fall bits

Behaviour:
- Reset: clk is the clock; reset is asynchronous and active-high.
  - On reset, all sync stages and q load RESET_VAL.
  - Debounce counters, rise, fall and changed go to 0.
  - No pulses are generated as a consequence of reset assertion or deassertion.
- Sync chain: per channel, a shift register of STAGES flops, shifting on every clk edge regardless of en. s denotes the last stage.
- Debounce, per channel, with counter width max(1, $clog2(DB_CYCLES)):
  - If s == q: counter <= 0.
  - Else if en == 0: counter holds.
  - Else if counter == DB_CYCLES-1: q <= s and counter <= 0.
  - Else: counter <= counter+1.
- Glitch rejection: if s returns to q before the count completes, the counter clears and q does not change.
- Edge pulses:
  - rise[i] = 1 and fall[i] = 0 in exactly the cycle q[i] first shows 1.
  - fall[i] = 1 and rise[i] = 0 in exactly the cycle q[i] first shows 0.
  - All outputs are registered; rise, fall and changed update on the same edge as q.
- Latency with en tied high: a stable change on d reaches q on the (STAGES + DB_CYCLES)-th clk edge after d changes.
  - Setup-meeting case only; metastability may add one edge.
- Channels are fully independent. Simultaneous rise on some bits and fall on others is legal; both vectors assert in the same cycle.
- Reset mid-count: the counter is discarded. After release, filtering restarts from RESET_VAL.
- STAGES < 2 or DB_CYCLES < 1 is an elaboration-time error ($error).
- The sync flops carry synthesis attributes marking them as asynchronous registers, with no logic between stages.

Test Plan:
1. N=4, STAGES=2, DB_CYCLES=4, en=1; d=4'hF set during reset, then reset released -> q=4'h0 until edge 6 after release. At edge 6: q=4'hF, rise=4'hF for one cycle only, changed=1, fall=0.
2. Same config, q=0; d[0] high for 3 cycles then low -> q[0] never changes; rise and changed stay 0.
3. Same config; en pulsed 1 cycle in every 4, d[2] 0->1 held -> q[2] rises only on the 4th en-high edge after s[2] goes high. Counter visibly holds between ticks.
4. q=4'b0100; d changes to 4'b0010 in one step -> on a single edge q=4'b0010, rise=4'b0010, fall=4'b0100, changed=1.
5. d[1] 0->1 with the counter at 2; reset pulsed for 1 cycle -> q and rise go to 0 immediately and asynchronously. After release, no pulse until a full 2+4 edges have elapsed.
6. STAGES=3, DB_CYCLES=1, en=1; d[3] toggles -> q[3] follows after exactly 4 edges, with one rise or fall pulse per toggle.
